// File: rtl/camera_pattern_pkg.sv
// camera_pattern_pkg: shared types and constants for the camera pattern source.
//   state_e        - frame timing FSM states
//   pattern_e      - test pattern codes selected per frame
//   PIXEL_W        - pixel data width
//   PAT_CONST_VAL  - value emitted by the constant pattern
//   max2()         - constant helper used to size the blanking counter
package camera_pattern_pkg;

  localparam int PIXEL_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    ACTIVE,
    HBLANK,
    TRAIL,
    VBLANK
  } state_e;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_DIAG  = 2'd2,
    PAT_CONST = 2'd3
  } pattern_e;

  localparam logic [PIXEL_W-1:0] PAT_CONST_VAL = 12'hA5A;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/camera_pattern_source_if.sv
// camera_pattern_source_if: sensor-side video bus.
//   frame_valid - FV, high for the whole frame
//   line_valid  - LV, high during active pixels
//   pixel_data  - pixel value, zero whenever LV is low
// modport master: the emulated sensor (drives the bus)
// modport slave : the camera input path (observes the bus)
interface camera_pattern_source_if;
  import camera_pattern_pkg::*;

  logic               frame_valid;
  logic               line_valid;
  logic [PIXEL_W-1:0] pixel_data;

  modport master (output frame_valid, output line_valid, output pixel_data);
  modport slave  (input  frame_valid, input  line_valid, input  pixel_data);

endinterface

// File: rtl/camera_pattern_pixel.sv
// camera_pattern_pixel: purely combinational test pattern function.
//   pattern - latched pattern code for the current frame
//   x, y    - active pixel coordinates
//   f       - frame count at frame start (low 12 bits)
//   value   - pixel value for (x, y) under the selected pattern
// The parent registers value together with LV, so no latency is added here.
module camera_pattern_pixel
  import camera_pattern_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  pattern_e           pattern,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic [PIXEL_W-1:0] f,
  output logic [PIXEL_W-1:0] value
);

  // All pattern arithmetic is done on zero-extended 12-bit operands so the
  // diagonal sum wraps modulo 4096.
  logic [PIXEL_W-1:0] x12;
  logic [PIXEL_W-1:0] y12;

  assign x12 = PIXEL_W'(x);
  assign y12 = PIXEL_W'(y);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no branch can
    // leave it unassigned and infer a latch.
    value = '0;
    case (pattern)
      PAT_RAMP:  value = {x12[9:0], 2'b00};
      PAT_CHECK: value = (x12[4] ^ y12[4]) ? '1 : '0;
      PAT_DIAG:  value = x12 + y12 + f;
      PAT_CONST: value = PAT_CONST_VAL;
    endcase
  end

endmodule

// File: rtl/camera_pattern_source.sv
// camera_pattern_source: synthetic image-sensor emulator.
//   clk_clk       - sole clock, all outputs registered on the rising edge
//   reset_reset_n - asynchronous active-low reset
//   enable        - frames run while high; a frame in flight always completes
//   pattern_sel   - pattern code, latched on entry to LEAD
//   video         - FV / LV / pixel_data bus (master side)
//   frame_count   - completed frames, wraps 0xFFFF -> 0
//   busy          - high in every state except IDLE
// Outputs are registered one cycle behind the FSM state, so FV rises one
// cycle after enable is seen in IDLE and LV/data line up in the same cycle.
module camera_pattern_source
  import camera_pattern_pkg::*;
#(
  parameter int ACTIVE_W = 640,
  parameter int ACTIVE_H = 480,
  parameter int H_BLANK  = 16,
  parameter int FV_LEAD  = 4,
  parameter int FV_TRAIL = 4,
  parameter int V_BLANK  = 32
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic                       enable,
  input  logic [1:0]                 pattern_sel,
  camera_pattern_source_if.master    video,
  output logic [15:0]                frame_count,
  output logic                       busy
);

  localparam int X_W     = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
  localparam int Y_W     = (ACTIVE_H > 1) ? $clog2(ACTIVE_H) : 1;
  localparam int DLY_MAX = max2(max2(FV_LEAD, H_BLANK), max2(FV_TRAIL, V_BLANK));
  localparam int CNT_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

  localparam logic [X_W-1:0]   X_LAST    = X_W'(ACTIVE_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(ACTIVE_H - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(FV_LEAD - 1);
  localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] TR_LAST   = CNT_W'(FV_TRAIL - 1);
  localparam logic [CNT_W-1:0] VB_LAST   = CNT_W'(V_BLANK - 1);

  state_e             state;
  state_e             state_next;
  logic [CNT_W-1:0]   cnt;       // cycles spent in the current timed state
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  pattern_e           pat_q;
  logic [PIXEL_W-1:0] pix;
  logic               fv_d;
  logic               lv_d;
  logic               busy_d;
  logic               fv_q;
  logic               lv_q;
  logic [PIXEL_W-1:0] pix_q;

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    // NOTE: sequential logic uses non-blocking assignments so every flop
    // samples the values present before the edge.
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable) state_next = LEAD;
      LEAD:    if (cnt == LEAD_LAST) state_next = ACTIVE;
      ACTIVE:  if (x == X_LAST) state_next = (y == Y_LAST) ? TRAIL : HBLANK;
      HBLANK:  if (cnt == HB_LAST) state_next = ACTIVE;
      TRAIL:   if (cnt == TR_LAST) state_next = VBLANK;
      // enable is only consulted here, so a mid-frame drop never truncates.
      VBLANK:  if (cnt == VB_LAST) state_next = enable ? LEAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode, registered below.
  always_comb begin
    fv_d   = 1'b0;
    lv_d   = 1'b0;
    busy_d = (state_next != IDLE);
    unique case (state)
      LEAD, HBLANK, TRAIL: fv_d = 1'b1;
      ACTIVE: begin
        fv_d = 1'b1;
        lv_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters, pattern latch and frame counter.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      pat_q       <= PAT_RAMP;
      frame_count <= '0;
    end else begin
      // The duration counter restarts on every state change.
      cnt <= (state_next != state) ? '0 : cnt + CNT_W'(1);

      if (state == ACTIVE) x <= (x == X_LAST) ? '0 : x + X_W'(1);

      if (state == LEAD)
        y <= '0;
      else if (state == ACTIVE && x == X_LAST && state_next == HBLANK)
        y <= y + Y_W'(1);

      if (state != LEAD && state_next == LEAD) pat_q <= pattern_e'(pattern_sel);

      if (state == TRAIL && state_next == VBLANK) frame_count <= frame_count + 16'd1;
    end
  end

  // frame_count only moves at TRAIL -> VBLANK, after the last active pixel,
  // so during active pixels it still holds the value from frame start.
  camera_pattern_pixel #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_pixel (
    .pattern (pat_q),
    .x       (x),
    .y       (y),
    .f       (frame_count[PIXEL_W-1:0]),
    .value   (pix)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fv_q  <= 1'b0;
      lv_q  <= 1'b0;
      pix_q <= '0;
      busy  <= 1'b0;
    end else begin
      fv_q  <= fv_d;
      lv_q  <= lv_d;
      pix_q <= lv_d ? pix : '0;
      busy  <= busy_d;
    end
  end

  assign video.frame_valid = fv_q;
  assign video.line_valid  = lv_q;
  assign video.pixel_data  = pix_q;

endmodule

// File: doc/camera_pattern_source.md
# camera_pattern_source

Synthetic image-sensor emulator. It drives the transmitter side of the camera input interface: `frame_valid`, `line_valid` and 12-bit `pixel_data`, one pixel per clock. It feeds the camera input path in place of the physical sensor for bring-up and for pattern-generator regression. Frame geometry is set by parameters, and one of four test patterns is selected per frame.

## Interface
- `ACTIVE_W`, 640: pixels per line (≥1)
- `ACTIVE_H`, 480: lines per frame (≥1)
- `H_BLANK`, 16: LV-low cycles between lines, FV high (≥1)
- `FV_LEAD`, 4: cycles from FV rise to first LV rise (≥1)
- `FV_TRAIL`, 4: cycles from last LV fall to FV fall (≥1)
- `V_BLANK`, 32: FV-low cycles between frames (≥1)
- `clk_clk`  in  1  sole clock; all outputs registered on rising edge
- `reset_reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  level; frames run while high
- `pattern_sel`  in  2  pattern code, sampled at frame start
- `frame_valid`  out  1  FV, high for whole frame
- `line_valid`  out  1  LV, high during active pixels
- `pixel_data`  out  12  pixel value; 0 whenever LV=0
- `frame_count`  out  16  completed frames, wraps 0xFFFF→0
- `busy`  out  1  high in any state except IDLE

## Operation
- States:
  - IDLE: FV=0, LV=0.
  - LEAD: FV=1, LV=0, lasts `FV_LEAD` cycles.
  - ACTIVE: FV=1, LV=1, lasts `ACTIVE_W` cycles.
  - HBLANK: FV=1, LV=0, lasts `H_BLANK` cycles.
  - TRAIL: FV=1, LV=0, lasts `FV_TRAIL` cycles.
  - VBLANK: FV=0, LV=0, lasts `V_BLANK` cycles.
- Transitions:
  - IDLE→LEAD when `enable`=1.
  - LEAD→ACTIVE (x=0, y=0).
  - ACTIVE at x=`ACTIVE_W`-1: to HBLANK if y<`ACTIVE_H`-1, else to TRAIL.
  - HBLANK→ACTIVE with y+1, x=0.
  - TRAIL→VBLANK; `frame_count` increments on this transition.
  - VBLANK end: to LEAD if `enable`=1, else IDLE.
- `enable` falling mid-frame does not truncate the frame. The frame completes, including VBLANK, then the block goes to IDLE.
- `pattern_sel` is latched on entry to LEAD and held constant for the frame.
- Patterns (x, y = active coordinates; f = `frame_count` at frame start):
  - 0, horizontal ramp: `{x[9:0],2'b00}`.
  - 1, checkerboard: `12'hFFF` if x[4]^y[4], else `12'h000`.
  - 2, moving diagonal: (x+y+f) mod 4096.
  - 3, constant `12'hA5A`.
- Arithmetic is unsigned. Zero-extend x, y and f to 12 bits before any sum; truncate the result to 12 bits.
- x and y counters are `$clog2` of their maximum +1 bits wide.

## Timing
- Reset values: all outputs 0; state IDLE; x=y=0; latched pattern=0.
- `enable` sampled high in IDLE at edge N → FV=1 after edge N+1.
- First LV=1 appears `FV_LEAD` cycles after FV rises. `pixel_data` is valid in the same cycle as LV (no extra latency).
- Frame period in continuous mode: `FV_LEAD` + `ACTIVE_H`·`ACTIVE_W` + (`ACTIVE_H`−1)·`H_BLANK` + `FV_TRAIL` + `V_BLANK` cycles.
- LV never rises while FV=0. FV never falls while LV=1.
- Reset asserted mid-frame: FV, LV and data drop to 0 asynchronously. On release the block restarts from IDLE; no partial frame resumes.

## Structure
- Package `camera_pattern_pkg` holds:
  - the state enum (IDLE, LEAD, ACTIVE, HBLANK, TRAIL, VBLANK);
  - pattern codes `PAT_RAMP`=0, `PAT_CHECK`=1, `PAT_DIAG`=2, `PAT_CONST`=3;
  - `PIXEL_W`=12;
  - `PAT_CONST_VAL`=`12'hA5A`.
- Sub-module `camera_pattern_pixel`: a combinational pattern function. Inputs: pattern, x, y, f. Output: 12-bit value. It is registered in the parent together with LV.

## Test plan
Bench parameters: W=8, H=4, H_BLANK=3, FV_LEAD=2, FV_TRAIL=2, V_BLANK=5.

- Reset, then `enable`=1 held → FV rises 1 cycle later. First LV after 2 cycles. 4 LV pulses of 8 cycles each, separated by 3-cycle gaps. FV falls 2 cycles after the last LV. Next FV rises 5 cycles later. Period is 50 cycles.
- `pattern_sel`=0 → line data 0x000, 0x004, …, 0x01C. `pattern_sel`=3 → every active pixel is 0xA5A. `pixel_data`=0 in every LV=0 cycle.
- `pattern_sel`=2 over frames 0 and 1 → pixel (x=3, y=2) reads 0x005, then 0x006. `frame_count` reads 1 after the first TRAIL→VBLANK.
- `pattern_sel` changed from 0 to 1 mid-frame → the current frame stays a ramp. The next frame is a checkerboard (all 0x000 at these sizes, since x, y < 16).
- `enable` dropped during line 1 → all 4 lines still emitted. The block enters IDLE after VBLANK and `busy`=0. Re-asserting `enable` starts a new frame.
- `reset_reset_n` pulsed low during ACTIVE → FV, LV and data go to 0 immediately. After release with `enable`=1, a full 4-line frame starts from y=0. `frame_count`=0.
